// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btb_pkg
//  Description : Shared types and constants for the BTB controller slice:
//                index/tag width defaults, entry field positions, 2-bit
//                counter encodings, controller FSM states, the update-FIFO
//                entry layout and the saturating counter helper.
//                When BTB_STATS_EN is defined, the FIFO entry also carries
//                an allocation flag so writes can be classified.
//  Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    localparam int BTB_IDX_W      = 10;
    localparam int BTB_TAG_W      = 20;
    localparam int BTB_FIFO_DEPTH = 2;

    // Entry layout: [54:53] counter, [52] valid, [51:32] tag, [31:0] target
    localparam int CNT_HI = 54;
    localparam int CNT_LO = 53;
    localparam int VALID  = 52;
    localparam int TAG_HI = 51;
    localparam int TAG_LO = 32;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        cnt_e        cnt;
`ifdef BTB_STATS_EN
        logic        alloc;
`endif
    } upd_entry_t;

    // Next counter value for a resolved branch. Misses allocate weakly-taken.
    function automatic cnt_e cnt_next(input logic hit, input logic taken, input cnt_e cnt);
        cnt_e res;
        if (!hit) begin
            res = CNT_WT;
        end else if (taken) begin
            res = (cnt == CNT_ST) ? CNT_ST : cnt_e'(cnt + 2'd1);
        end else begin
            res = (cnt == CNT_SNT) ? CNT_SNT : cnt_e'(cnt - 2'd1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_upd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : btb_upd_fifo
//  Description : Small synchronous FIFO holding pending BTB update entries.
//                Pointer-based with an extra wrap bit; clear has priority
//                over push and pop. Push when full / pop when empty are
//                ignored.
//  Ports       : i_clk, i_rst_n (async active-low), i_clear, i_push, i_pop,
//                i_data (entry in), o_data (head entry), o_full, o_empty
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = BTB_FIFO_DEPTH
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_push,
    input  logic       i_pop,
    input  upd_entry_t i_data,
    output upd_entry_t o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int               c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE = 1;

    upd_entry_t         r_mem [DEPTH];
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign o_data    = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_do_push = i_push && !o_full && !i_clear;
    assign w_do_pop  = i_pop && !o_empty && !i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btb_ctrl
//  Description : Owner of the single address/write port of the branch target
//                buffer. Sweeps the array to zero after reset and on
//                invalidate-all, buffers resolved-branch updates from EX and
//                writes them back (counter update or new allocation), stealing
//                the port from fetch only when fetch is already held or the
//                buffer is full.
//  Ports       : i_clk, i_rst_n (async active-low)
//                i_fetch_pc, i_fe_hold, i_flush_all
//                i_upd_valid/pc/target/taken/hit/cnt -> o_upd_ready
//                o_btb_addr, o_btb_wren, o_btb_data (to BTB array)
//                o_fetch_stall, o_busy
//                o_stat_alloc/upd/steal (only with BTB_STATS_EN defined)
//  Options     : BTB_STATS_EN - adds free-running write statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int IDX_W      = BTB_IDX_W,
    parameter int TAG_W      = BTB_TAG_W,
    parameter int FIFO_DEPTH = BTB_FIFO_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_fe_hold,
    input  logic        i_flush_all,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_taken,
    input  logic        i_upd_hit,
    input  logic [1:0]  i_upd_cnt,
    output logic        o_upd_ready,
    output logic [31:0] o_btb_addr,
    output logic        o_btb_wren,
    output logic [54:0] o_btb_data,
    output logic        o_fetch_stall,
    output logic        o_busy
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] o_stat_alloc,
    output logic [31:0] o_stat_upd,
    output logic [31:0] o_stat_steal
`endif
);

    localparam logic [IDX_W-1:0] c_IDX_LAST = '1;
    localparam logic [IDX_W-1:0] c_IDX_ONE  = 1;

    state_e           r_state;
    logic [IDX_W-1:0] r_idx;

    logic             w_run;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    upd_entry_t       w_push_entry;
    upd_entry_t       w_head;
    logic [31:0]      w_sweep_addr;
    logic [54:0]      w_upd_data;

    assign w_run        = (r_state == S_RUN);
    assign o_upd_ready  = w_run && !w_fifo_full && !i_flush_all;
    assign w_accept     = i_upd_valid && o_upd_ready;
    // A not-taken miss has nothing worth allocating: accept it, store nothing.
    assign w_push       = w_accept && (i_upd_hit || i_upd_taken);
    // Write only when fetch is held anyway, or when the buffer cannot take
    // more. A flush cycle writes nothing since the sweep wipes it regardless.
    assign w_pop        = w_run && !w_fifo_empty && (i_fe_hold || w_fifo_full) && !i_flush_all;
    assign w_sweep_addr = {{(30-IDX_W){1'b0}}, r_idx, 2'b00};

    // Counter is resolved at push time so the write path is just a mux.
    always_comb begin
        w_push_entry        = '0;
        w_push_entry.pc     = i_upd_pc;
        w_push_entry.target = i_upd_target;
        w_push_entry.cnt    = cnt_next(i_upd_hit, i_upd_taken, cnt_e'(i_upd_cnt));
`ifdef BTB_STATS_EN
        w_push_entry.alloc  = !i_upd_hit;
`endif
    end

    always_comb begin
        w_upd_data                 = '0;
        w_upd_data[CNT_HI:CNT_LO]  = w_head.cnt;
        w_upd_data[VALID]          = 1'b1;
        w_upd_data[TAG_HI:TAG_LO]  = w_head.pc[31:32-TAG_W];
        w_upd_data[31:0]           = w_head.target;
    end

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush_all),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Sweep outputs come straight from state/index registers, so the reset
    // values (write of zero to address 0, stall, busy) appear the moment
    // reset is asserted. In S_RUN the port must pass the fetch PC through in
    // the same cycle, so that path is combinational.
    always_comb begin
        o_btb_wren    = 1'b0;
        o_btb_addr    = i_fetch_pc;
        o_btb_data    = '0;
        o_fetch_stall = 1'b0;
        o_busy        = 1'b0;
        if (!w_run) begin
            o_btb_wren    = 1'b1;
            o_btb_addr    = w_sweep_addr;
            o_fetch_stall = 1'b1;
            o_busy        = 1'b1;
        end else if (w_pop) begin
            o_btb_wren    = 1'b1;
            o_btb_addr    = w_head.pc;
            o_btb_data    = w_upd_data;
            o_fetch_stall = !i_fe_hold;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INIT;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_INIT, S_FLUSH: begin
                    if (i_flush_all) begin
                        r_idx <= '0;
                    end else if (r_idx == c_IDX_LAST) begin
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                S_RUN: begin
                    if (i_flush_all) begin
                        r_idx   <= '0;
                        r_state <= S_FLUSH;
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_state <= S_INIT;
                end
            endcase
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_alloc <= '0;
            o_stat_upd   <= '0;
            o_stat_steal <= '0;
        end else if (w_pop) begin
            if (w_head.alloc) begin
                o_stat_alloc <= o_stat_alloc + 32'd1;
            end else begin
                o_stat_upd <= o_stat_upd + 32'd1;
            end
            if (!i_fe_hold) begin
                o_stat_steal <= o_stat_steal + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
- Owns the single address/write port of the branch target buffer (1024 entries, 55-bit entry).
- After reset, and on request, it sweeps the whole array to clear stale entries.
- Buffers resolved-branch updates from EX in a small FIFO and performs saturating 2-bit counter updates and new-entry allocations.
- Steals the port from fetch only when needed and raises a fetch stall whenever it does.

Parameters:
- IDX_W, 10, BTB index width; index = pc[IDX_W+1:2], entry count 2**IDX_W.
- TAG_W, 20, tag width; tag = pc[31:32-TAG_W].
- FIFO_DEPTH, 2, update FIFO depth; must be a power of two, minimum 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fetch_pc  in  32  fetch-stage lookup address.
- i_fe_hold  in  1  fetch already stalled by a hazard this cycle; a free slot for a BTB write.
- i_flush_all  in  1  invalidate-all request (fence.i / context switch), single-cycle pulse.
- i_upd_valid  in  1  EX has a resolved control-transfer instruction.
- i_upd_pc  in  32  PC of that instruction.
- i_upd_target  in  32  resolved target.
- i_upd_taken  in  1  branch actually taken.
- i_upd_hit  in  1  BTB hit when this instruction was fetched.
- i_upd_cnt  in  2  counter value read at fetch, carried down the pipe.
- o_upd_ready  out  1  update accepted this cycle.
- o_btb_addr  out  32  address to the BTB (lookup or write).
- o_btb_wren  out  1  BTB write enable.
- o_btb_data  out  55  entry: [54:53] counter, [52] valid, [51:32] tag, [31:0] target.
- o_fetch_stall  out  1  fetch must hold its PC this cycle.
- o_busy  out  1  sweep in progress.

Behaviour:
- Reset and timing:
  - One clock domain.
  - Reset is asynchronous, active-low.
  - Reset values: o_btb_wren=1, o_btb_data=0, o_btb_addr=0, o_fetch_stall=1, o_busy=1, o_upd_ready=0, FIFO empty, sweep index=0, state=S_INIT.
- FSM has three states: S_INIT, S_RUN, S_FLUSH.
- S_INIT and S_FLUSH (sweep):
  - Each cycle: o_btb_wren=1, o_btb_data=0, o_btb_addr={pc tag 0, idx, 2'b00}, index+1.
  - o_fetch_stall=1, o_busy=1, o_upd_ready=0.
  - After index 2**IDX_W-1 is written, go to S_RUN. The sweep takes exactly 2**IDX_W cycles.
- Entering S_FLUSH: i_flush_all while in S_RUN. The FIFO is cleared, index=0, and any in-flight push that cycle is dropped.
- i_flush_all during a sweep restarts the index at 0.
- Reset asserted mid-sweep or mid-write aborts the operation and returns to S_INIT.
- S_RUN, default: o_btb_addr=i_fetch_pc, o_btb_wren=0, o_fetch_stall=0.
- Push:
  - o_upd_ready = (state==S_RUN) && !full && !i_flush_all.
  - A push happens when i_upd_valid && o_upd_ready.
  - Push rule: hit → always push; miss → push only if i_upd_taken. A miss that is not taken is accepted and discarded.
- Pop/write:
  - Condition: FIFO non-empty && (i_fe_hold || full).
  - That cycle: o_btb_wren=1, o_btb_addr=head pc, o_btb_data={cnt_next, 1'b1, head tag, head target}.
  - o_fetch_stall = !i_fe_hold.
  - A push and a pop in the same cycle are both legal.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Hit: taken → cnt+1, saturating at 11; not taken → cnt-1, saturating at 00.
  - Miss allocation: cnt_next=10.
  - The computation is done at push time and the result is stored in the FIFO.
- Latency: earliest write is the cycle after the push. Fetch never sees a write and a lookup in the same cycle.
- Entry contents: valid is always 1 on update writes. Hit entries that have decayed to 00 are still written, not invalidated.

Optional Feature:
- Macro: BTB_STATS_EN.
- With it defined, add outputs o_stat_alloc[31:0], o_stat_upd[31:0], o_stat_steal[31:0], all reset to 0, each wrapping at 2**32:
  - o_stat_alloc: miss allocations written.
  - o_stat_upd: hit updates written.
  - o_stat_steal: writes that forced o_fetch_stall=1.
  - Sweeps do not clear them.
- Without it, these ports and counters do not exist.

Decomposition:
- Package btb_pkg holds:
  - IDX_W and TAG_W defaults.
  - Entry field positions (CNT_HI=54, CNT_LO=53, VALID=52, TAG_HI=51, TAG_LO=32).
  - Counter encodings as an enum.
  - FSM state enum {S_INIT, S_RUN, S_FLUSH}.
  - A packed struct for a FIFO entry {pc, target, cnt}.
- One sub-module: btb_upd_fifo, a synchronous FIFO with push/pop/full/empty/clear, same reset.

Test Plan:
- Reset release with IDX_W=10 → exactly 1024 write cycles, addresses 0x000..0xFFC, data 0, stall=1; stall drops in cycle 1025.
- Hit update pc=0x0000_1040, cnt=11, taken=1, i_fe_hold=1 next cycle → write at addr 0x1040, data[54:52]=3'b111, tag=0x00001; stall stays 0.
- Miss, not-taken push → o_upd_ready=1, no write ever issued. Miss, taken pc=0x8000_0100, target 0x8000_0200 → data={2'b10,1'b1,20'h80000,32'h8000_0200}.
- Two pushes with i_fe_hold=0 → FIFO full, o_upd_ready=0, next cycle write with o_fetch_stall=1; after the pop, ready returns to 1.
- i_flush_all with FIFO holding 1 entry → entry never written, sweep of 1024 cycles, o_busy=1 throughout; a second flush at sweep index 500 restarts at 0.
- Reset asserted at sweep index 300 → outputs return to reset values immediately; sweep restarts at 0 after release.
